// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and id/index helpers for the reorder buffer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ID_W     = 5;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int IDX_W    = $clog2(ROB_SIZE);
  localparam int CNT_W    = $clog2(ROB_SIZE + 1);

  localparam logic [ID_W-1:0]  INVALID_ROB = '0;
  localparam logic [REG_W-1:0] ZERO_REG    = '0;

  // Ids are index+1 so that 0 can mean "no producer"; anything above
  // ROB_SIZE would alias a real slot and is treated as invalid.
  function automatic logic id_in_range(input logic [ID_W-1:0] id);
    return (id != INVALID_ROB) && (id <= ID_W'(ROB_SIZE));
  endfunction

  function automatic logic [IDX_W-1:0] id_to_idx(input logic [ID_W-1:0] id);
    return IDX_W'(id - ID_W'(1));
  endfunction

  function automatic logic [ID_W-1:0] idx_to_id(input logic [IDX_W-1:0] idx);
    return ID_W'(idx) + ID_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(ROB_SIZE - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand lookup: returns an entry's result, bypassing same-cycle ALU/LSB writebacks.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; answers every query every cycle.
// Ports: q_id in -> q_ready/q_value out; entry_ready/entry_value are the ROB's stored
//        result fields; alu_* / lsb_* are the writeback strobes of the current cycle.
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [ID_W-1:0]                  q_id,
  input  logic [ROB_SIZE-1:0]              entry_ready,
  input  logic [ROB_SIZE-1:0][DATA_W-1:0]  entry_value,
  input  logic                             alu_valid,
  input  logic [ID_W-1:0]                  alu_rob_id,
  input  logic [DATA_W-1:0]                alu_value,
  input  logic                             lsb_valid,
  input  logic [ID_W-1:0]                  lsb_rob_id,
  input  logic [DATA_W-1:0]                lsb_value,
  output logic                             q_ready,
  output logic [DATA_W-1:0]                q_value
);

  logic [IDX_W-1:0] idx;
  assign idx = id_to_idx(q_id);

  // Bypass order mirrors the storage update: ALU overrides LSB, and a
  // writeback this cycle is newer than whatever is already stored.
  always_comb begin
    q_ready = 1'b0;
    q_value = '0;
    if (id_in_range(q_id)) begin
      if (alu_valid && (alu_rob_id == q_id)) begin
        q_ready = 1'b1;
        q_value = alu_value;
      end else if (lsb_valid && (lsb_rob_id == q_id)) begin
        q_ready = 1'b1;
        q_value = lsb_value;
      end else if (entry_ready[idx]) begin
        q_ready = 1'b1;
        q_value = entry_value[idx];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates ids, captures writebacks, retires one per cycle.
// Latency: writeback edge E -> registered commit pulse after edge E+1; queries are combinational.
// Backpressure: rob_full (registered count) blocks dispatch; rollback_sign also drops dispatch.
// Ports: dispatch_* in / alloc_rob_id, rob_full out; alu_* / lsb_* writeback in;
//        q1_*/q2_* operand queries; commit_* to reg file / LSB; rollback_* flush to the core.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dispatch_valid,
  input  logic [REG_W-1:0]  dispatch_rd,
  input  logic              dispatch_is_br,
  input  logic              dispatch_is_store,
  input  logic              dispatch_pred,
  input  logic [DATA_W-1:0] dispatch_pc,
  output logic [ID_W-1:0]   alloc_rob_id,
  output logic              rob_full,
  input  logic              alu_valid,
  input  logic [ID_W-1:0]   alu_rob_id,
  input  logic [DATA_W-1:0] alu_value,
  input  logic              alu_taken,
  input  logic [DATA_W-1:0] alu_target,
  input  logic              lsb_valid,
  input  logic [ID_W-1:0]   lsb_rob_id,
  input  logic [DATA_W-1:0] lsb_value,
  input  logic [ID_W-1:0]   q1_id,
  input  logic [ID_W-1:0]   q2_id,
  output logic              q1_ready,
  output logic [DATA_W-1:0] q1_value,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q2_value,
  output logic              commit_sign,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_V,
  output logic [ID_W-1:0]   commit_Q,
  output logic              commit_store,
  output logic              rollback_sign,
  output logic [DATA_W-1:0] rollback_pc
);

  // Per-field entry storage
  logic [ROB_SIZE-1:0]              busy_q, busy_d, ready_q, ready_d;
  logic [ROB_SIZE-1:0]              is_br_q, is_br_d, is_store_q, is_store_d;
  logic [ROB_SIZE-1:0]              pred_q, pred_d, taken_q, taken_d;
  logic [ROB_SIZE-1:0][REG_W-1:0]   rd_q, rd_d;
  logic [ROB_SIZE-1:0][DATA_W-1:0]  value_q, value_d, target_q, target_d, pc_q, pc_d;
  logic [IDX_W-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                 count_q, count_d;

  // Registered retirement outputs
  logic              commit_sign_q, commit_sign_d, commit_store_q, commit_store_d;
  logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0] commit_v_q, commit_v_d;
  logic [ID_W-1:0]   commit_q_q, commit_q_d;
  logic              rollback_sign_q, rollback_sign_d;
  logic [DATA_W-1:0] rollback_pc_q, rollback_pc_d;

  logic             dispatch_ok, alu_hit, lsb_hit, head_ready, mispredict;
  logic [IDX_W-1:0] alu_idx, lsb_idx;

  assign rob_full     = (count_q == CNT_W'(ROB_SIZE));
  assign alloc_rob_id = idx_to_id(tail_q);
  assign dispatch_ok  = dispatch_valid && !rob_full && !rollback_sign_q;

  assign alu_idx = id_to_idx(alu_rob_id);
  assign lsb_idx = id_to_idx(lsb_rob_id);
  assign alu_hit = alu_valid && id_in_range(alu_rob_id) && busy_q[alu_idx];
  assign lsb_hit = lsb_valid && id_in_range(lsb_rob_id) && busy_q[lsb_idx];

  assign head_ready = busy_q[head_q] && ready_q[head_q];
  assign mispredict = head_ready && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    is_br_d    = is_br_q;
    is_store_d = is_store_q;
    pred_d     = pred_q;
    taken_d    = taken_q;
    rd_d       = rd_q;
    value_d    = value_q;
    target_d   = target_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    commit_sign_d   = 1'b0;
    commit_store_d  = 1'b0;
    commit_rd_d     = ZERO_REG;
    commit_v_d      = '0;
    commit_q_d      = INVALID_ROB;
    rollback_sign_d = 1'b0;
    rollback_pc_d   = '0;

    if (dispatch_ok) begin
      busy_d[tail_q]     = 1'b1;
      ready_d[tail_q]    = 1'b0;
      is_br_d[tail_q]    = dispatch_is_br;
      is_store_d[tail_q] = dispatch_is_store;
      pred_d[tail_q]     = dispatch_pred;
      taken_d[tail_q]    = 1'b0;
      rd_d[tail_q]       = dispatch_rd;
      value_d[tail_q]    = '0;
      target_d[tail_q]   = '0;
      pc_d[tail_q]       = dispatch_pc;
      tail_d             = next_idx(tail_q);
    end

    // LSB first so an ALU write to the same id overrides it.
    if (lsb_hit) begin
      value_d[lsb_idx] = lsb_value;
      ready_d[lsb_idx] = 1'b1;
    end
    if (alu_hit) begin
      value_d[alu_idx]  = alu_value;
      ready_d[alu_idx]  = 1'b1;
      taken_d[alu_idx]  = alu_taken;
      target_d[alu_idx] = alu_target;
    end

    if (head_ready) begin
      commit_sign_d  = !is_store_q[head_q];
      commit_store_d = is_store_q[head_q];
      commit_rd_d    = is_store_q[head_q] ? ZERO_REG : rd_q[head_q];
      commit_v_d     = (commit_rd_d == ZERO_REG) ? '0 : value_q[head_q];
      commit_q_d     = idx_to_id(head_q);
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = next_idx(head_q);
    end

    case ({dispatch_ok, head_ready})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A mispredicted branch still retires normally (its rd is written),
    // but everything younger is discarded, including this cycle's dispatch.
    if (mispredict) begin
      rollback_sign_d = 1'b1;
      rollback_pc_d   = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + DATA_W'(4);
      busy_d          = '0;
      ready_d         = '0;
      head_d          = '0;
      tail_d          = '0;
      count_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q          <= '0;
      ready_q         <= '0;
      is_br_q         <= '0;
      is_store_q      <= '0;
      pred_q          <= '0;
      taken_q         <= '0;
      rd_q            <= '0;
      value_q         <= '0;
      target_q        <= '0;
      pc_q            <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_sign_q   <= 1'b0;
      commit_store_q  <= 1'b0;
      commit_rd_q     <= ZERO_REG;
      commit_v_q      <= '0;
      commit_q_q      <= INVALID_ROB;
      rollback_sign_q <= 1'b0;
      rollback_pc_q   <= '0;
    end else begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      is_br_q         <= is_br_d;
      is_store_q      <= is_store_d;
      pred_q          <= pred_d;
      taken_q         <= taken_d;
      rd_q            <= rd_d;
      value_q         <= value_d;
      target_q        <= target_d;
      pc_q            <= pc_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_sign_q   <= commit_sign_d;
      commit_store_q  <= commit_store_d;
      commit_rd_q     <= commit_rd_d;
      commit_v_q      <= commit_v_d;
      commit_q_q      <= commit_q_d;
      rollback_sign_q <= rollback_sign_d;
      rollback_pc_q   <= rollback_pc_d;
    end
  end

  assign commit_sign   = commit_sign_q;
  assign commit_store  = commit_store_q;
  assign commit_rd     = commit_rd_q;
  assign commit_V      = commit_v_q;
  assign commit_Q      = commit_q_q;
  assign rollback_sign = rollback_sign_q;
  assign rollback_pc   = rollback_pc_q;

  rob_query_port u_q1 (
    .q_id        (q1_id),
    .entry_ready (ready_q),
    .entry_value (value_q),
    .alu_valid   (alu_valid),
    .alu_rob_id  (alu_rob_id),
    .alu_value   (alu_value),
    .lsb_valid   (lsb_valid),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_value   (lsb_value),
    .q_ready     (q1_ready),
    .q_value     (q1_value)
  );

  rob_query_port u_q2 (
    .q_id        (q2_id),
    .entry_ready (ready_q),
    .entry_value (value_q),
    .alu_valid   (alu_valid),
    .alu_rob_id  (alu_rob_id),
    .alu_value   (alu_value),
    .lsb_valid   (lsb_valid),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_value   (lsb_value),
    .q_ready     (q2_ready),
    .q_value     (q2_value)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected retirements, a monitor checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic [4:0]  dispatch_rd = '0;
  logic        dispatch_is_br = 1'b0;
  logic        dispatch_is_store = 1'b0;
  logic        dispatch_pred = 1'b0;
  logic [31:0] dispatch_pc = '0;
  logic [4:0]  alloc_rob_id;
  logic        rob_full;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rob_id = '0;
  logic [31:0] alu_value = '0;
  logic        alu_taken = 1'b0;
  logic [31:0] alu_target = '0;
  logic        lsb_valid = 1'b0;
  logic [4:0]  lsb_rob_id = '0;
  logic [31:0] lsb_value = '0;
  logic [4:0]  q1_id = '0;
  logic [4:0]  q2_id = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_sign, commit_store, rollback_sign;
  logic [4:0]  commit_rd;
  logic [31:0] commit_V, rollback_pc;
  logic [4:0]  commit_Q;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd),
    .dispatch_is_br(dispatch_is_br), .dispatch_is_store(dispatch_is_store),
    .dispatch_pred(dispatch_pred), .dispatch_pc(dispatch_pc),
    .alloc_rob_id(alloc_rob_id), .rob_full(rob_full),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .alu_taken(alu_taken), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .q1_id(q1_id), .q2_id(q2_id),
    .q1_ready(q1_ready), .q1_value(q1_value), .q2_ready(q2_ready), .q2_value(q2_value),
    .commit_sign(commit_sign), .commit_rd(commit_rd), .commit_V(commit_V),
    .commit_Q(commit_Q), .commit_store(commit_store),
    .rollback_sign(rollback_sign), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic        store;
    logic [4:0]  rd;
    logic [31:0] v;
    logic [4:0]  q;
    logic        rb;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_commit(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] q,
                             input logic store);
    exp_t e;
    e.sign = !store; e.store = store; e.rd = rd; e.v = v; e.q = q; e.rb = 1'b0; e.rpc = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_rollback(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] q,
                               input logic [31:0] rpc);
    exp_t e;
    e.sign = 1'b1; e.store = 1'b0; e.rd = rd; e.v = v; e.q = q; e.rb = 1'b1; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  // Monitor: any retirement or rollback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (commit_sign || commit_store || rollback_sign)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: got sign=%0b store=%0b rb=%0b Q=%0d, required none at %0t",
                 commit_sign, commit_store, rollback_sign, commit_Q, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_sign", 32'(commit_sign), 32'(mon_e.sign));
        check("commit_store", 32'(commit_store), 32'(mon_e.store));
        check("commit_rd", 32'(commit_rd), 32'(mon_e.rd));
        check("commit_V", commit_V, mon_e.v);
        check("commit_Q", 32'(commit_Q), 32'(mon_e.q));
        check("rollback_sign", 32'(rollback_sign), 32'(mon_e.rb));
        if (mon_e.rb) check("rollback_pc", rollback_pc, mon_e.rpc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wb();
    alu_valid = 1'b0; lsb_valid = 1'b0; alu_taken = 1'b0;
    alu_rob_id = '0; lsb_rob_id = '0;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic is_br, input logic is_store,
                          input logic pred, input logic [31:0] pc);
    dispatch_valid = 1'b1; dispatch_rd = rd; dispatch_is_br = is_br;
    dispatch_is_store = is_store; dispatch_pred = pred; dispatch_pc = pc;
    tick();
    dispatch_valid = 1'b0; dispatch_is_br = 1'b0; dispatch_is_store = 1'b0; dispatch_pred = 1'b0;
  endtask

  task automatic alu_wb(input logic [4:0] id, input logic [31:0] v, input logic taken,
                        input logic [31:0] tgt);
    alu_valid = 1'b1; alu_rob_id = id; alu_value = v; alu_taken = taken; alu_target = tgt;
  endtask

  task automatic lsb_wb(input logic [4:0] id, input logic [31:0] v);
    lsb_valid = 1'b1; lsb_rob_id = id; lsb_value = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("reset_alloc_id", 32'(alloc_rob_id), 32'd1);
    check("reset_rob_full", 32'(rob_full), 32'd0);
    check("reset_commit_Q", 32'(commit_Q), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- In-order retirement with out-of-order writeback ----
    check("alloc_id1", 32'(alloc_rob_id), 32'd1);
    dispatch(5'd5, 1'b0, 1'b0, 1'b0, 32'h100);
    check("alloc_id2", 32'(alloc_rob_id), 32'd2);
    dispatch(5'd6, 1'b0, 1'b0, 1'b0, 32'h104);
    check("alloc_id3", 32'(alloc_rob_id), 32'd3);
    dispatch(5'd7, 1'b0, 1'b0, 1'b0, 32'h108);
    alu_wb(5'd2, 32'h22, 1'b0, '0);
    tick();
    alu_wb(5'd1, 32'h11, 1'b0, '0);
    push_commit(5'd5, 32'h11, 5'd1, 1'b0);
    push_commit(5'd6, 32'h22, 5'd2, 1'b0);
    tick();
    idle_wb();
    repeat (5) tick();
    check("blocked_by_id3_drained", 32'(exp_q.size()), 32'd0);
    check("alloc_before_rst", 32'(alloc_rob_id), 32'd4);

    // ---- Reset mid-operation ----
    rst_n = 1'b0;
    #2;
    check("midrst_alloc_id", 32'(alloc_rob_id), 32'd1);
    check("midrst_rob_full", 32'(rob_full), 32'd0);
    check("midrst_commit_sign", 32'(commit_sign), 32'd0);
    check("midrst_commit_store", 32'(commit_store), 32'd0);
    check("midrst_rollback", 32'(rollback_sign), 32'd0);
    check("midrst_commit_rd", 32'(commit_rd), 32'd0);
    check("midrst_commit_V", commit_V, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // ---- Fill, full refusal, commit/dispatch interplay and wrap ----
    for (int i = 1; i <= 16; i++) dispatch(5'(i), 1'b0, 1'b0, 1'b0, 32'(i * 4));
    check("full_after_16", 32'(rob_full), 32'd1);
    dispatch(5'd31, 1'b0, 1'b0, 1'b0, 32'h999);
    check("17th_ignored_full", 32'(rob_full), 32'd1);
    check("17th_ignored_alloc", 32'(alloc_rob_id), 32'd1);
    alu_wb(5'd1, 32'h100, 1'b0, '0);
    lsb_wb(5'd2, 32'h200);
    push_commit(5'd1, 32'h100, 5'd1, 1'b0);
    push_commit(5'd2, 32'h200, 5'd2, 1'b0);
    tick();
    idle_wb();
    dispatch_valid = 1'b1; dispatch_rd = 5'd20;
    check("full_before_commit", 32'(rob_full), 32'd1);
    tick();
    check("refused_on_commit_edge_full", 32'(rob_full), 32'd0);
    check("refused_on_commit_edge_alloc", 32'(alloc_rob_id), 32'd1);
    tick();
    check("wrap_reuse_alloc", 32'(alloc_rob_id), 32'd2);
    check("wrap_reuse_full", 32'(rob_full), 32'd0);
    dispatch_rd = 5'd21;
    tick();
    dispatch_valid = 1'b0;
    check("count_held_full", 32'(rob_full), 32'd1);
    check("count_held_alloc", 32'(alloc_rob_id), 32'd3);
    do_reset();

    // ---- Branch mispredict and rollback ----
    dispatch(5'd8, 1'b0, 1'b0, 1'b0, 32'h3f4);
    dispatch(5'd9, 1'b0, 1'b0, 1'b0, 32'h3f8);
    dispatch(5'd10, 1'b0, 1'b0, 1'b0, 32'h3fc);
    dispatch(5'd0, 1'b1, 1'b0, 1'b0, 32'h400);
    dispatch(5'd11, 1'b0, 1'b0, 1'b0, 32'h404);
    check("br_alloc_after5", 32'(alloc_rob_id), 32'd6);
    alu_wb(5'd1, 32'h81, 1'b0, '0);
    lsb_wb(5'd5, 32'h55);
    push_commit(5'd8, 32'h81, 5'd1, 1'b0);
    tick();
    idle_wb();
    alu_wb(5'd2, 32'h91, 1'b0, '0);
    push_commit(5'd9, 32'h91, 5'd2, 1'b0);
    tick();
    alu_wb(5'd3, 32'hA1, 1'b0, '0);
    push_commit(5'd10, 32'hA1, 5'd3, 1'b0);
    tick();
    alu_wb(5'd4, 32'h404, 1'b1, 32'h1000);
    push_rollback(5'd0, 32'h0, 5'd4, 32'h1000);
    tick();
    idle_wb();
    tick();
    check("rollback_pulse", 32'(rollback_sign), 32'd1);
    check("rollback_alloc", 32'(alloc_rob_id), 32'd1);
    check("rollback_not_full", 32'(rob_full), 32'd0);
    dispatch(5'd9, 1'b0, 1'b0, 1'b0, 32'h1000);
    check("dispatch_dropped_in_rollback", 32'(alloc_rob_id), 32'd1);
    repeat (4) tick();

    // ---- Store retirement ----
    check("store_alloc", 32'(alloc_rob_id), 32'd1);
    dispatch(5'd3, 1'b0, 1'b1, 1'b0, 32'h2000);
    lsb_wb(5'd1, 32'hDEAD);
    push_commit(5'd0, 32'h0, 5'd1, 1'b1);
    tick();
    idle_wb();
    repeat (2) tick();

    // ---- Query bypass ----
    dispatch(5'd12, 1'b0, 1'b0, 1'b0, 32'h2004);
    dispatch(5'd13, 1'b0, 1'b0, 1'b0, 32'h2008);
    q1_id = 5'd3; q2_id = 5'd2;
    lsb_wb(5'd3, 32'hABCD);
    #1;
    check("q1_bypass_ready", 32'(q1_ready), 32'd1);
    check("q1_bypass_value", q1_value, 32'hABCD);
    check("q2_not_ready", 32'(q2_ready), 32'd0);
    q2_id = 5'd0;
    #1;
    check("q2_id0_ready", 32'(q2_ready), 32'd0);
    check("q2_id0_value", q2_value, 32'd0);
    tick();
    idle_wb();
    #1;
    check("q1_stored_ready", 32'(q1_ready), 32'd1);
    check("q1_stored_value", q1_value, 32'hABCD);
    q2_id = 5'd2;
    alu_wb(5'd2, 32'h1, 1'b0, '0);
    lsb_wb(5'd2, 32'h2);
    #1;
    check("q2_alu_priority", q2_value, 32'h1);
    push_commit(5'd12, 32'h1, 5'd2, 1'b0);
    push_commit(5'd13, 32'hABCD, 5'd3, 1'b0);
    tick();
    idle_wb();
    repeat (5) tick();
    check("all_expected_retired", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
